// File: rtl/uriscv_intc_pkg.sv
// Shared definitions for the uriscv interrupt controller: register offsets,
// controller FSM states and the vector address helper.
package uriscv_intc_pkg;

  // Width of a source id; covers up to 31 sources and id+1 claim values.
  localparam int unsigned ID_W = 5;

  localparam logic [3:0] REG_PENDING = 4'h0;
  localparam logic [3:0] REG_ENABLE  = 4'h4;
  localparam logic [3:0] REG_EDGE    = 4'h8;
  localparam logic [3:0] REG_CLAIM   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  // ISR entry address for a given source id.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [ID_W-1:0] id);
    return base + ({{(32-ID_W){1'b0}}, id} * stride);
  endfunction

endpackage

// File: rtl/uriscv_intc_prio.sv
// Fixed lowest-index-wins priority encoder over the enabled pending vector.
module uriscv_intc_prio
  import uriscv_intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/uriscv_intc.sv
// uriscv interrupt controller: pending/enable registers, fixed-priority
// candidate selection and an IDLE/REQ/SERVICE claim-complete handshake.
// Optional feature macro: URISCV_INTC_EDGE_EN adds the EDGE register and
// per-source rising-edge detection; without it every source is level mode.
module uriscv_intc
  import uriscv_intc_pkg::*;
#(
  parameter int          NUM_SRC       = 8,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter logic [31:0] VECTOR_STRIDE = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               reg_valid_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o
);

  intc_state_e        state_r, state_s;
  logic [NUM_SRC-1:0] pending_r, enable_r, set_s, clr_s;
  logic [ID_W-1:0]    in_service_r, cand_id_s;
  logic               cand_valid_s;
  logic               rd_s, wr_s, claim_rd_s, complete_s;
  logic [31:0]        edge_rd_s, rd_mux_s;
  logic               intr_r, ack_r;
  logic [31:0]        vector_r, rdata_r;

  assign rd_s = reg_valid_i & ~reg_we_i;
  assign wr_s = reg_valid_i & reg_we_i;

  uriscv_intc_prio #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (pending_r & enable_r),
    .valid (cand_valid_s),
    .id    (cand_id_s)
  );

  // Only a claim read in REQ with a live candidate has side effects.
  assign claim_rd_s = rd_s && (reg_addr_i == REG_CLAIM) && (state_r == ST_REQ) && cand_valid_s;
  assign complete_s = wr_s && (reg_addr_i == REG_CLAIM) && (state_r == ST_SERVICE) &&
                      (reg_wdata_i == {{(32-ID_W){1'b0}}, in_service_r + ID_W'(1)});

`ifdef URISCV_INTC_EDGE_EN
  logic [NUM_SRC-1:0] edge_cfg_r, prev_r;

  // EDGE configuration register and previous-sample register for rise detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cfg_r <= '0;
      prev_r     <= '0;
    end else begin
      prev_r <= irq_src_i;
      if (wr_s && (reg_addr_i == REG_EDGE)) edge_cfg_r <= reg_wdata_i[NUM_SRC-1:0];
      else edge_cfg_r <= edge_cfg_r;
    end
  end

  assign set_s     = (irq_src_i & ~edge_cfg_r) | (irq_src_i & ~prev_r & edge_cfg_r);
  assign edge_rd_s = {{(32-NUM_SRC){1'b0}}, edge_cfg_r};
`else
  assign set_s     = irq_src_i;
  assign edge_rd_s = 32'd0;
`endif

  // One-hot clear for the source being claimed this cycle.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_s[i] = claim_rd_s && (cand_id_s == ID_W'(i));
    end
  end

  // Pending bits: a new set wins over a same-cycle claim so no edge is lost.
  always_ff @(posedge clk) begin
    if (rst) pending_r <= '0;
    else pending_r <= (pending_r & ~clr_s) | set_s;
  end

  // ENABLE register; the FSM sees a new value from the following cycle.
  always_ff @(posedge clk) begin
    if (rst) enable_r <= '0;
    else if (wr_s && (reg_addr_i == REG_ENABLE)) enable_r <= reg_wdata_i[NUM_SRC-1:0];
    else enable_r <= enable_r;
  end

  // Latch the claimed id so completion can be matched against it.
  always_ff @(posedge clk) begin
    if (rst) in_service_r <= '0;
    else if (claim_rd_s) in_service_r <= cand_id_s;
    else in_service_r <= in_service_r;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else state_r <= state_s;
  end

  // Next-state logic for the request/claim/complete handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cand_valid_s) state_s = ST_REQ;
        else state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (!cand_valid_s) state_s = ST_IDLE;
        else if (claim_rd_s) state_s = ST_SERVICE;
        else state_s = ST_REQ;
      end
      ST_SERVICE: begin
        if (complete_s) state_s = ST_IDLE;
        else state_s = ST_SERVICE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Register read multiplexer; CLAIM returns id+1 only when the claim takes.
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_addr_i)
      REG_PENDING: rd_mux_s = {{(32-NUM_SRC){1'b0}}, pending_r};
      REG_ENABLE:  rd_mux_s = {{(32-NUM_SRC){1'b0}}, enable_r};
      REG_EDGE:    rd_mux_s = edge_rd_s;
      REG_CLAIM: begin
        if (claim_rd_s) rd_mux_s = {{(32-ID_W){1'b0}}, cand_id_s + ID_W'(1)};
        else rd_mux_s = 32'd0;
      end
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // Registered bus response: one ack per request, data qualified by ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= reg_valid_i;
      rdata_r <= rd_s ? rd_mux_s : 32'd0;
    end
  end

  // Interrupt request and vector, registered from the next state so the
  // vector tracks the candidate while requesting and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_r   <= 1'b0;
      vector_r <= VECTOR_BASE;
    end else begin
      intr_r   <= (state_s == ST_REQ);
      vector_r <= (state_s == ST_REQ) ? vec_addr(VECTOR_BASE, VECTOR_STRIDE, cand_id_s) : vector_r;
    end
  end

  assign reg_ack_o    = ack_r;
  assign reg_rdata_o  = rdata_r;
  assign intr_o       = intr_r;
  assign isr_vector_o = vector_r;

endmodule
